tap_controller: RTL and testbench

- IEEE 1149.1 TAP controller and instruction register that sits directly upstream of the bypass, IDCODE and boundary-scan data registers.
- Runs the 16-state TAP FSM from tms.
- Holds and decodes a 4-bit instruction.
- Generates clkDR/shiftDR/updateDR/mode/select strobes for the data registers.
- Multiplexes their serial outputs onto tdo.

---
 rtl/tap_controller.sv | 165 ++++++++++++++++
 tb/tb_tap_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller with a 4-bit instruction register and DR steering.
// State, IR shift stage: posedge tck. IR hold stage, tdo, tdo_en, DR clock enable, updateDR:
// negedge tck. Optional macro TAP_SAMPLE_EN adds SAMPLE/PRELOAD (opcode 0010) as a BSR
// instruction; without it 0010 falls through to BYPASS.
module tap_controller #(
  parameter int unsigned        IR_LEN     = 4,
  parameter logic [IR_LEN-1:0]  IR_CAPTURE = 4'b0101
) (
  input  logic              tck,
  input  logic              reset,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic              tdo_en,
  input  logic              tdo_bypass,
  input  logic              tdo_id,
  input  logic              tdo_bsr,
  output logic              clkDR,
  output logic              shiftDR,
  output logic              updateDR,
  output logic              mode,
  output logic              sel_bypass,
  output logic              sel_id,
  output logic              sel_bsr,
  output logic              bsr_reset,
  output logic [IR_LEN-1:0] ir_out
);

  localparam logic [IR_LEN-1:0] OpExtest = '0;
  localparam logic [IR_LEN-1:0] OpIdcode = IR_LEN'(1);
`ifdef TAP_SAMPLE_EN
  localparam logic [IR_LEN-1:0] OpSample = IR_LEN'(2);
`endif

  typedef enum logic [3:0] {
    StTlr, StRti, StSelDr, StCapDr, StShDr, StEx1Dr, StPauseDr, StEx2Dr, StUpdDr,
    StSelIr, StCapIr, StShIr, StEx1Ir, StPauseIr, StEx2Ir, StUpdIr
  } tap_state_e;

  tap_state_e        r_state;
  logic [IR_LEN-1:0] r_ir_shift;
  logic [IR_LEN-1:0] r_ir;
  logic              r_clk_en;
  logic              r_update;
  logic              r_tdo;
  logic              r_tdo_en;

  logic [IR_LEN-1:0] w_ir;
  logic              w_sel_bypass;
  logic              w_sel_id;
  logic              w_sel_bsr;
  logic              w_mode;
  logic              w_dr_tdo;

  // TAP state machine, advanced by tms on the rising edge
  always_ff @(posedge tck or negedge reset) begin
    if (!reset) begin
      r_state <= StTlr;
    end else begin
      case (r_state)
        StTlr:     r_state <= tms ? StTlr     : StRti;
        StRti:     r_state <= tms ? StSelDr   : StRti;
        StSelDr:   r_state <= tms ? StSelIr   : StCapDr;
        StCapDr:   r_state <= tms ? StEx1Dr   : StShDr;
        StShDr:    r_state <= tms ? StEx1Dr   : StShDr;
        StEx1Dr:   r_state <= tms ? StUpdDr   : StPauseDr;
        StPauseDr: r_state <= tms ? StEx2Dr   : StPauseDr;
        StEx2Dr:   r_state <= tms ? StUpdDr   : StShDr;
        StUpdDr:   r_state <= tms ? StSelDr   : StRti;
        StSelIr:   r_state <= tms ? StTlr     : StCapIr;
        StCapIr:   r_state <= tms ? StEx1Ir   : StShIr;
        StShIr:    r_state <= tms ? StEx1Ir   : StShIr;
        StEx1Ir:   r_state <= tms ? StUpdIr   : StPauseIr;
        StPauseIr: r_state <= tms ? StEx2Ir   : StPauseIr;
        StEx2Ir:   r_state <= tms ? StUpdIr   : StShIr;
        StUpdIr:   r_state <= tms ? StSelDr   : StRti;
        default:   r_state <= StTlr;
      endcase
    end
  end

  // IR shift stage: capture fixed pattern, then shift right with tdi entering at the MSB
  always_ff @(posedge tck or negedge reset) begin
    if (!reset) begin
      r_ir_shift <= IR_CAPTURE;
    end else if (r_state == StCapIr) begin
      r_ir_shift <= IR_CAPTURE;
    end else if (r_state == StShIr) begin
      r_ir_shift <= {tdi, r_ir_shift[IR_LEN-1:1]};
    end
  end

  // Falling-edge stage: IR hold, DR clock enable, update strobe and serial output
  always_ff @(negedge tck or negedge reset) begin
    if (!reset) begin
      r_ir     <= OpIdcode;
      r_clk_en <= 1'b0;
      r_update <= 1'b0;
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_clk_en <= (r_state == StCapDr) || (r_state == StShDr);
      r_update <= (r_state == StUpdDr);
      r_tdo_en <= (r_state == StShIr) || (r_state == StShDr);
      if (r_state == StTlr) begin
        r_ir <= OpIdcode;
      end else if (r_state == StUpdIr) begin
        r_ir <= r_ir_shift;
      end
      if (r_state == StTlr) begin
        r_tdo <= 1'b0;
      end else if (r_state == StShIr) begin
        r_tdo <= r_ir_shift[0];
      end else if (r_state == StShDr) begin
        r_tdo <= w_dr_tdo;
      end
    end
  end

  // TLR forces IDCODE at once, so entering it by tms matches the async reset immediately
  assign w_ir = (r_state == StTlr) ? OpIdcode : r_ir;

  // Instruction decode; anything unrecognised selects the bypass register
  always_comb begin
    w_sel_bypass = 1'b0;
    w_sel_id     = 1'b0;
    w_sel_bsr    = 1'b0;
    w_mode       = 1'b0;
    case (w_ir)
      OpIdcode: w_sel_id = 1'b1;
      OpExtest: begin
        w_sel_bsr = 1'b1;
        w_mode    = 1'b1;
      end
`ifdef TAP_SAMPLE_EN
      OpSample: w_sel_bsr = 1'b1;
`endif
      default:  w_sel_bypass = 1'b1;
    endcase
  end

  // Serial-out mux of the selected data register
  always_comb begin
    w_dr_tdo = tdo_bypass;
    if (w_sel_bsr) begin
      w_dr_tdo = tdo_bsr;
    end else if (w_sel_id) begin
      w_dr_tdo = tdo_id;
    end
  end

  // Enable changes only while tck is low, so the AND cannot glitch
  assign clkDR      = tck & r_clk_en;
  assign shiftDR    = (r_state == StShDr);
  assign updateDR   = r_update;
  assign mode       = w_mode;
  assign sel_bypass = w_sel_bypass;
  assign sel_id     = w_sel_id;
  assign sel_bsr    = w_sel_bsr;
  assign bsr_reset  = (r_state == StTlr);
  assign ir_out     = w_ir;
  assign tdo        = r_tdo;
  assign tdo_en     = r_tdo_en;

endmodule

// File: tb/tb_tap_controller.sv
// Bench for tap_controller: directed TMS/TDI sequences, behavioural bypass/IDCODE/BSR
// registers, and a tdo scoreboard popped whenever tdo_en is high.
module tb_tap_controller;

  localparam int          Period = 10;
  localparam logic [31:0] IdCode = 32'h1234_5679;
  localparam logic [7:0]  BsrCap = 8'hA5;

  logic       tck   = 1'b0;
  logic       reset = 1'b0;
  logic       tms   = 1'b1;
  logic       tdi   = 1'b0;
  logic       tdo, tdo_en, tdo_bypass, tdo_id, tdo_bsr;
  logic       clkDR, shiftDR, updateDR, mode;
  logic       sel_bypass, sel_id, sel_bsr, bsr_reset;
  logic [3:0] ir_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic exp_q[$];

  // Data register models
  logic        r_bp  = 1'b0;
  logic [31:0] r_id  = 32'h0;
  logic [7:0]  r_bsr = 8'h0;
  logic        sh_lat = 1'b0;

  int  clk_cnt = 0;
  int  sh_cnt  = 0;
  int  upd_cnt = 0;
  time t_rise  = 0;
  time upd_w   = 0;

  tap_controller dut (
    .tck        (tck),
    .reset      (reset),
    .tms        (tms),
    .tdi        (tdi),
    .tdo        (tdo),
    .tdo_en     (tdo_en),
    .tdo_bypass (tdo_bypass),
    .tdo_id     (tdo_id),
    .tdo_bsr    (tdo_bsr),
    .clkDR      (clkDR),
    .shiftDR    (shiftDR),
    .updateDR   (updateDR),
    .mode       (mode),
    .sel_bypass (sel_bypass),
    .sel_id     (sel_id),
    .sel_bsr    (sel_bsr),
    .bsr_reset  (bsr_reset),
    .ir_out     (ir_out)
  );

  always #(Period / 2) tck = ~tck;

  assign tdo_bypass = r_bp;
  assign tdo_id     = r_id[0];
  assign tdo_bsr    = r_bsr[0];

  always @(negedge tck) begin
    sh_lat = shiftDR;
    if (shiftDR) sh_cnt++;
  end

  always @(posedge clkDR) begin
    clk_cnt++;
    if (sel_bypass) r_bp  <= sh_lat ? tdi : 1'b0;
    if (sel_id)     r_id  <= sh_lat ? {tdi, r_id[31:1]} : IdCode;
    if (sel_bsr)    r_bsr <= sh_lat ? {tdi, r_bsr[7:1]} : BsrCap;
  end

  always @(posedge updateDR) begin
    upd_cnt++;
    t_rise = $time;
  end
  always @(negedge updateDR) upd_w = $time - t_rise;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard monitor: every tdo_en sample must match the next queued bit
  always @(negedge tck) begin
    #1;
    if (tdo_en) begin
      if (exp_q.size() == 0) check("tdo_unexpected", 32'(tdo_en), 32'd0);
      else check("tdo", 32'(tdo), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  task automatic check_idle(input string name);
    check(name, 32'({ir_out, sel_bypass, sel_id, sel_bsr, mode, bsr_reset, tdo_en, shiftDR,
                     updateDR}),
          32'({4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
  endtask

  // RTI -> load opcode -> RTI; IR scan always returns the capture pattern 0101 LSB first
  task automatic ir_load(input logic [3:0] op);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(i == 3, op[i]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // RTI -> capture, shift n bits of din (LSB first), update -> RTI
  task automatic dr_scan(input int n, input logic [31:0] din);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick(i == n - 1, din[i]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] id_v;
    logic [7:0]  bsr_v;
    id_v  = IdCode;
    bsr_v = BsrCap;

    // Reset state
    #2;
    check_idle("reset_state");
    check("reset_clkdr", 32'(clkDR), 32'd0);
    check("reset_tdo", 32'(tdo), 32'd0);
    @(negedge tck);
    #2 reset = 1'b1;

    // Reset asserted in the middle of Shift-DR
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    exp_q.push_back(id_v[0]);
    exp_q.push_back(id_v[1]);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("in_shdr", 32'(shiftDR), 32'd1);
    reset = 1'b0;
    #2;
    check_idle("reset_mid_shdr");
    @(negedge tck);
    #2 reset = 1'b1;
    check_idle("after_release");
    check("q_drain_reset", 32'(exp_q.size()), 32'd0);

    // Five tms=1 from RTI and from Shift-IR both end in TLR
    tick(1'b0, 1'b0);
    check("rti_not_tlr", 32'(bsr_reset), 32'd0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    check("tms5_from_rti", 32'(bsr_reset), 32'd1);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    exp_q.push_back(1'b1);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
    check_idle("tms5_from_shir");

    // BYPASS load, then a 1011 DR scan delayed one tck through the bypass bit
    tick(1'b0, 1'b0);
    ir_load(4'b1111);
    check("bypass_ir", 32'(ir_out), 32'hF);
    check("bypass_sel", 32'({sel_bypass, sel_id, sel_bsr, mode}), 32'b1000);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    dr_scan(4, 32'b1101);
    check("q_drain_bypass", 32'(exp_q.size()), 32'd0);

    // IDCODE after reset: 33 DR clocks, 32 shift cycles, tdo equals the ID stream
    reset = 1'b0;
    #2 reset = 1'b1;
    check("idcode_after_reset", 32'(ir_out), 32'h1);
    tick(1'b0, 1'b0);
    clk_cnt = 0;
    sh_cnt  = 0;
    for (int i = 0; i < 32; i++) exp_q.push_back(id_v[i]);
    dr_scan(32, 32'h0);
    check("idcode_clkdr", 32'(clk_cnt), 32'd33);
    check("idcode_shiftdr", 32'(sh_cnt), 32'd32);
    check("q_drain_idcode", 32'(exp_q.size()), 32'd0);

    // EXTEST: BSR selected, mode high, exactly one update strobe, falling to falling edge
    ir_load(4'b0000);
    check("extest_sel", 32'({sel_bypass, sel_id, sel_bsr, mode}), 32'b0011);
    for (int i = 0; i < 8; i++) exp_q.push_back(bsr_v[i]);
    upd_cnt = 0;
    dr_scan(8, 32'h3C);
    @(negedge tck);
    #1;
    check("extest_upd_count", 32'(upd_cnt), 32'd1);
    check("extest_upd_width", 32'(upd_w), 32'(Period));
    check("extest_mode", 32'({sel_bsr, mode, bsr_reset}), 32'b110);
    check("q_drain_extest", 32'(exp_q.size()), 32'd0);

    // SAMPLE/PRELOAD opcode depends on the build; 0111 is always BYPASS
    ir_load(4'b0010);
`ifdef TAP_SAMPLE_EN
    check("op_0010", 32'({sel_bypass, sel_id, sel_bsr, mode}), 32'b0010);
`else
    check("op_0010", 32'({sel_bypass, sel_id, sel_bsr, mode}), 32'b1000);
`endif
    ir_load(4'b0111);
    check("op_0111", 32'({sel_bypass, sel_id, sel_bsr, mode}), 32'b1000);
    check("op_0111_ir", 32'(ir_out), 32'h7);
    check("q_drain_final", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
